// File: rtl/mul_pkg.sv
// Shared types for the multiplier issue path.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } e_mul_issue_state;

endpackage

// File: rtl/mul_req_fifo.sv
// Synchronous request FIFO; power-of-two depth, storage cleared on reset.
module mul_req_fifo #(
    parameter int data_width = 69,
    parameter int depth      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [data_width-1:0]      din,
    output logic [data_width-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth):0]     count
);

    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = ptr_w + 1;

    logic [data_width-1:0] mem [depth];
    logic [ptr_w-1:0]      rd_ptr;
    logic [ptr_w-1:0]      wr_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == cnt_w'(depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + ptr_w'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_issue_queue.sv
// Queues multiply ops and issues them one at a time to the iterative multiplier,
// holding each result with its tag until writeback accepts it.
//
// state | meaning
// IDLE  | waiting for a queued op; issues the FIFO head when not empty
// BUSY  | one op in flight, waiting for mul_ack
// DONE  | result held on wb_data/wb_tag until wb_ready
module mul_issue_queue
    import mul_pkg::*;
#(
    parameter int width     = 32,
    parameter int depth     = 2,
    parameter int tag_width = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_a,
    input  logic [width-1:0]     in_b,
    input  logic [tag_width-1:0] in_tag,
    output logic                 mul_req,
    output logic [width-1:0]     mul_a,
    output logic [width-1:0]     mul_b,
    input  logic [width-1:0]     mul_out,
    input  logic                 mul_ack,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [width-1:0]     wb_data,
    output logic [tag_width-1:0] wb_tag
);

    localparam int entry_w = 2 * width + tag_width;
    localparam int cnt_w   = $clog2(depth) + 1;

    e_mul_issue_state     state;
    e_mul_issue_state     state_nxt;
    logic [entry_w-1:0]   head;
    logic                 full;
    logic                 empty;
    logic [cnt_w-1:0]     count;
    logic [tag_width-1:0] busy_tag;

    // in_ready comes from the registered count only, so no path from wb_ready/mul_ack.
    assign in_ready = (count < cnt_w'(depth));

    mul_req_fifo #(
        .data_width (entry_w),
        .depth      (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (mul_req),
        .din   ({in_a, in_b, in_tag}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty)              state_nxt = BUSY;
            BUSY:    if (mul_ack)             state_nxt = DONE;
            DONE:    if (wb_ready)            state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_req  = (state == IDLE) && !empty;
        wb_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_tag <= '0;
            wb_data  <= '0;
            wb_tag   <= '0;
        end else begin
            if (mul_req) begin
                busy_tag <= head[tag_width-1:0];
            end
            // Acks outside BUSY are spurious and must not disturb the held result.
            if ((state == BUSY) && mul_ack) begin
                wb_data <= mul_out;
                wb_tag  <= busy_tag;
            end
        end
    end

    assign mul_a = head[entry_w-1 -: width];
    assign mul_b = head[tag_width +: width];

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Directed bench for mul_issue_queue with a behavioural 16-cycle multiplier model.
module tb_mul_issue_queue;

    localparam int W   = 32;
    localparam int TW  = 5;
    localparam int LAT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          mul_req;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_out;
    logic          mul_ack;
    logic          wb_valid;
    logic          wb_ready;
    logic [W-1:0]  wb_data;
    logic [TW-1:0] wb_tag;

    logic          m_busy;
    logic [4:0]    m_cnt;
    logic [W-1:0]  m_a;
    logic [W-1:0]  m_b;
    logic [W-1:0]  m_out;
    logic          m_ack;
    logic          spur_ack;
    logic [W-1:0]  spur_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_issue_queue #(.width(W), .depth(2), .tag_width(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .mul_req  (mul_req),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_out  (mul_out),
        .mul_ack  (mul_ack),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_tag   (wb_tag)
    );

    assign mul_ack = m_ack | spur_ack;
    assign mul_out = spur_ack ? spur_out : m_out;

    // Multiplier model: samples mul_req, pulses ack LAT edges later with the low product.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_out  <= '0;
            m_ack  <= 1'b0;
        end else begin
            m_ack <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_ack  <= 1'b1;
                    m_out  <= m_a * m_b;
                end else begin
                    m_cnt <= m_cnt - 5'd1;
                end
            end else if (mul_req) begin
                m_busy <= 1'b1;
                m_cnt  <= 5'(LAT - 1);
                m_a    <= mul_a;
                m_b    <= mul_b;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one op for one edge and reports whether it was taken.
    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] t, output bit accepted);
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        in_valid = 1'b1;
        #1 accepted = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!wb_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_wait"}, 64'(wb_valid), 64'd1);
    endtask

    task automatic wait_result(input logic [W-1:0] exp_d, input logic [TW-1:0] exp_t, input string tag);
        wait_valid(tag);
        check_val({tag, "_data"}, 64'(wb_data), 64'(exp_d));
        check_val({tag, "_tag"}, 64'(wb_tag), 64'(exp_t));
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        int extra;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        wb_ready = 1'b1;
        spur_ack = 1'b0;
        spur_out = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_mul_req", 64'(mul_req), 64'd0);
        check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst_mul_a", 64'(mul_a), 64'd0);
        check_val("rst_mul_b", 64'(mul_b), 64'd0);
        check_val("rst_wb_data", 64'(wb_data), 64'd0);
        check_val("rst_wb_tag", 64'(wb_tag), 64'd0);

        // Single op 7*6
        in_a = 32'd7; in_b = 32'd6; in_tag = 5'd3; in_valid = 1'b1;
        #1;
        check_val("single_not_same_cycle", 64'(mul_req), 64'd0);
        check_val("single_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("single_req", 64'(mul_req), 64'd1);
        check_val("single_mul_a", 64'(mul_a), 64'd7);
        check_val("single_mul_b", 64'(mul_b), 64'd6);
        @(negedge clk);
        check_val("single_req_pulse", 64'(mul_req), 64'd0);
        n = 0;
        while (!mul_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("single_ack_seen", 64'(mul_ack), 64'd1);
        check_val("single_valid_not_yet", 64'(wb_valid), 64'd0);
        @(negedge clk);
        check_val("single_valid", 64'(wb_valid), 64'd1);
        check_val("single_data", 64'(wb_data), 64'd42);
        check_val("single_tag", 64'(wb_tag), 64'd3);
        @(negedge clk);
        check_val("single_valid_one_cycle", 64'(wb_valid), 64'd0);

        // Fill and backpressure
        wb_ready = 1'b0;
        push_op(32'hFFFF_FFFF, 32'd2, 5'd1, acc);
        check_val("fill_acc1", 64'(acc), 64'd1);
        push_op(32'd3, 32'd4, 5'd2, acc);
        check_val("fill_acc2", 64'(acc), 64'd1);
        push_op(32'd5, 32'd6, 5'd3, acc);
        check_val("fill_acc3", 64'(acc), 64'd1);
        check_val("fill_in_ready", 64'(in_ready), 64'd0);
        check_val("fill_busy_no_req", 64'(mul_req), 64'd0);
        push_op(32'd1, 32'd1, 5'd4, acc);
        check_val("fill_acc4_refused", 64'(acc), 64'd0);
        wait_valid("fill_first_done");
        wb_ready = 1'b1;
        wait_result(32'hFFFF_FFFE, 5'd1, "fill_r1");
        wait_result(32'd12, 5'd2, "fill_r2");
        wait_result(32'd30, 5'd3, "fill_r3");
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_valid) extra++;
        end
        check_val("fill_no_4th", 64'(extra), 64'd0);
        check_val("fill_drained_ready", 64'(in_ready), 64'd1);
        check_val("fill_drained_req", 64'(mul_req), 64'd0);

        // Result hold in DONE, FIFO still accepts, spurious ack ignored
        wb_ready = 1'b0;
        push_op(32'd9, 32'd9, 5'd7, acc);
        wait_valid("hold_done");
        push_op(32'd2, 32'd3, 5'd8, acc);
        check_val("hold_acc1", 64'(acc), 64'd1);
        push_op(32'd4, 32'd4, 5'd10, acc);
        check_val("hold_acc2", 64'(acc), 64'd1);
        push_op(32'd1, 32'd1, 5'd11, acc);
        check_val("hold_acc3_refused", 64'(acc), 64'd0);
        for (int i = 0; i < 10; i++) begin
            spur_ack = (i == 5);
            spur_out = 32'hDEAD_BEEF;
            @(negedge clk);
            check_val("hold_valid", 64'(wb_valid), 64'd1);
            check_val("hold_data", 64'(wb_data), 64'd81);
            check_val("hold_tag", 64'(wb_tag), 64'd7);
            check_val("hold_no_req", 64'(mul_req), 64'd0);
        end
        spur_ack = 1'b0;
        wb_ready = 1'b1;
        wait_result(32'd81, 5'd7, "hold_r1");
        wait_result(32'd6, 5'd8, "hold_r2");
        wait_result(32'd16, 5'd10, "hold_r3");
        repeat (20) @(negedge clk);

        // Spurious ack in IDLE, empty
        spur_ack = 1'b1;
        spur_out = 32'd1234;
        @(negedge clk);
        check_val("spur_valid0", 64'(wb_valid), 64'd0);
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        check_val("spur_valid1", 64'(wb_valid), 64'd0);
        check_val("spur_data_kept", 64'(wb_data), 64'd16);
        check_val("spur_no_req", 64'(mul_req), 64'd0);
        push_op(32'd2, 32'd2, 5'd1, acc);
        check_val("spur_still_idle", 64'(mul_req), 64'd1);
        wait_result(32'd4, 5'd1, "spur_after");

        // Reset while BUSY with one entry queued
        push_op(32'd11, 32'd11, 5'd4, acc);
        push_op(32'd5, 32'd5, 5'd5, acc);
        repeat (3) @(negedge clk);
        check_val("rstmid_busy", 64'(mul_req), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rstmid_in_ready", 64'(in_ready), 64'd1);
        check_val("rstmid_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rstmid_mul_req", 64'(mul_req), 64'd0);
        check_val("rstmid_mul_a", 64'(mul_a), 64'd0);
        check_val("rstmid_wb_tag", 64'(wb_tag), 64'd0);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (wb_valid || mul_req) extra++;
        end
        check_val("rstmid_quiet", 64'(extra), 64'd0);
        push_op(32'd3, 32'd5, 5'd9, acc);
        wait_result(32'd15, 5'd9, "rstmid_new");

        // Simultaneous push and pop
        push_op(32'd6, 32'd7, 5'd12, acc);
        check_val("simul_req", 64'(mul_req), 64'd1);
        push_op(32'd8, 32'd8, 5'd13, acc);
        check_val("simul_acc", 64'(acc), 64'd1);
        check_val("simul_count", 64'(dut.u_fifo.count), 64'd1);
        check_val("simul_in_ready", 64'(in_ready), 64'd1);
        check_val("simul_busy", 64'(mul_req), 64'd0);
        wait_result(32'd42, 5'd12, "simul_r1");
        wait_result(32'd64, 5'd13, "simul_r2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
